lvds_tx_framer: RTL

Parametrised LVDS transmit framer. It produces per-lane parallel words for the OSERDES lane array and the forwarded-clock lane. It adds three things on top of raw pass-through: a link-training phase, periodic sync-word framing, and idle-pattern fill driven by a valid/ready handshake. It sits between the user TX datapath and the OSERDES/OBUFDS interface, all in the divided (parallel) clock domain.

---
 rtl/lvds_tx_pkg.sv | 60 ++++++
 rtl/lvds_tx_framer_prbs.sv | 28 ++
 rtl/lvds_tx_framer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared types, default patterns and bit-manipulation helpers for the LVDS TX framer.
// The LVDS_TX_PRBS_EN macro enables the PRBS7 test-pattern path in lvds_tx_framer.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_DATA  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SRC_ZERO  = 3'd0,
        SRC_TRAIN = 3'd1,
        SRC_SYNC  = 3'd2,
        SRC_IDLE  = 3'd3,
        SRC_DATA  = 3'd4,
        SRC_PRBS  = 3'd5
    } src_e;

    localparam logic [7:0] TRAIN_PAT_DEF = 8'hF0;
    localparam logic [7:0] SYNC_PAT_DEF  = 8'hB5;
    localparam logic [7:0] IDLE_PAT_DEF  = 8'h3C;
    // Forwarded-clock word: bit 0 = 1, alternating, wide enough for SER_W up to 10
    localparam logic [9:0] CLK_PAT_ALT   = 10'h155;

    // Advance PRBS7 (x^7+x^6+1) nbits times; returns {word[9:0], next_state[6:0]},
    // word holds the generated bits in its low nbits, first-generated bit highest.
    function automatic logic [16:0] prbs7_step(input logic [6:0] seed, input int nbits);
        logic [6:0] s;
        logic [9:0] w;
        logic       nb;
        s  = seed;
        w  = 10'd0;
        nb = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k < nbits) begin
                nb = s[6] ^ s[5];
                s  = {s[5:0], nb};
                w  = {w[8:0], nb};
            end
        end
        return {w, s};
    endfunction

    // Reverse the low nbits of w; bits above nbits come back as zero.
    function automatic logic [9:0] bit_rev(input logic [9:0] w, input int nbits);
        logic [9:0] r;
        logic [9:0] t;
        r = 10'd0;
        t = w;
        for (int k = 0; k < 10; k++) begin
            if (k < nbits) begin
                r = {r[8:0], t[0]};
                t = t >> 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lvds_tx_framer_prbs.sv
// Single-lane PRBS7 generator (lvds_tx_prbs); used only when LVDS_TX_PRBS_EN is defined.
module lvds_tx_prbs
    import lvds_tx_pkg::*;
#(
    parameter int         SER_W = 8,
    parameter logic [6:0] SEED  = 7'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [SER_W-1:0] word
);

    logic [6:0] lfsr_r;

    assign word = SER_W'(prbs7_step(lfsr_r, SER_W) >> 5'd7);

    // Sequence advances only when its word is actually transmitted, so payload stays contiguous
    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr_r <= SEED;
        end else if (adv) begin
            lfsr_r <= 7'(prbs7_step(lfsr_r, SER_W));
        end
    end

endmodule

// File: rtl/lvds_tx_framer.sv
// LVDS transmit framer: link training, periodic sync framing and idle fill over a valid/ready port.
// Define LVDS_TX_PRBS_EN to add per-lane PRBS7 payload selected by TEST_MODE.
module lvds_tx_framer
    import lvds_tx_pkg::*;
#(
    parameter int               DB_W      = 16,
    parameter int               SER_W     = 8,
    parameter int               TRAIN_LEN = 256,
    parameter int               FRAME_LEN = 64,
    parameter logic [SER_W-1:0] TRAIN_PAT = SER_W'(TRAIN_PAT_DEF),
    parameter logic [SER_W-1:0] SYNC_PAT  = SER_W'(SYNC_PAT_DEF),
    parameter logic [SER_W-1:0] IDLE_PAT  = SER_W'(IDLE_PAT_DEF)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    RETRAIN,
    input  logic                    TEST_MODE,
    input  logic                    TX_DVLD,
    output logic                    TX_RDY,
    input  logic [DB_W*SER_W-1:0]   TX_DATA,
    output logic [DB_W*SER_W-1:0]   OSER_DATA,
    output logic [SER_W-1:0]        OSER_CLK_PAT,
    output logic                    LINK_UP,
    output logic [15:0]             FRAME_CNT
);

    localparam int TC_W = (TRAIN_LEN > 2) ? $clog2(TRAIN_LEN) : 1;
    localparam int SC_W = $clog2(FRAME_LEN + 1);

    state_e                  state_r, state_nxt_s;
    logic [TC_W-1:0]         train_cnt_r, train_cnt_nxt_s;
    logic [SC_W-1:0]         slot_cnt_r, slot_cnt_nxt_s;
    logic [15:0]             frame_cnt_r;
    logic                    frame_inc_s;
    logic                    tx_rdy_s;
    logic                    prbs_sel_s;
    src_e                    src_s;
    logic [DB_W*SER_W-1:0]   oser_nxt_s, oser_data_r;
    logic [SER_W-1:0]        clk_pat_r;
    logic                    link_up_r;

`ifdef LVDS_TX_PRBS_EN
    assign prbs_sel_s = TEST_MODE;
`else
    logic test_mode_unused_s;
    assign test_mode_unused_s = TEST_MODE;
    assign prbs_sel_s         = 1'b0;
`endif

    // RST gating keeps the source from seeing an accept that reset would discard
    assign tx_rdy_s = !RST && EN && !RETRAIN && !prbs_sel_s &&
                      (state_r == S_DATA) && (slot_cnt_r != SC_W'(0));

    // Next state and counters; EN low wins over every other request
    always_comb begin
        state_nxt_s     = state_r;
        train_cnt_nxt_s = train_cnt_r;
        slot_cnt_nxt_s  = slot_cnt_r;
        if (!EN) begin
            state_nxt_s     = S_IDLE;
            train_cnt_nxt_s = TC_W'(0);
            slot_cnt_nxt_s  = SC_W'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt_s     = S_TRAIN;
                    train_cnt_nxt_s = TC_W'(0);
                end
                S_TRAIN: begin
                    if (RETRAIN) begin
                        train_cnt_nxt_s = TC_W'(0);
                    end else if (train_cnt_r == TC_W'(TRAIN_LEN - 1)) begin
                        state_nxt_s     = S_DATA;
                        train_cnt_nxt_s = TC_W'(0);
                        slot_cnt_nxt_s  = SC_W'(0);
                    end else begin
                        train_cnt_nxt_s = train_cnt_r + TC_W'(1);
                    end
                end
                S_DATA: begin
                    if (RETRAIN) begin
                        state_nxt_s     = S_TRAIN;
                        train_cnt_nxt_s = TC_W'(0);
                        slot_cnt_nxt_s  = SC_W'(0);
                    end else if (slot_cnt_r == SC_W'(FRAME_LEN)) begin
                        slot_cnt_nxt_s  = SC_W'(0);
                    end else begin
                        slot_cnt_nxt_s  = slot_cnt_r + SC_W'(1);
                    end
                end
                default: begin
                    state_nxt_s     = S_IDLE;
                    train_cnt_nxt_s = TC_W'(0);
                    slot_cnt_nxt_s  = SC_W'(0);
                end
            endcase
        end
    end

    // Word source for this cycle, shared by all lanes
    always_comb begin
        src_s       = SRC_ZERO;
        frame_inc_s = 1'b0;
        if (!EN) begin
            src_s = SRC_ZERO;
        end else begin
            case (state_r)
                S_TRAIN: src_s = SRC_TRAIN;
                S_DATA: begin
                    if (slot_cnt_r == SC_W'(0)) begin
                        src_s       = SRC_SYNC;
                        frame_inc_s = 1'b1;
                    end else if (tx_rdy_s && TX_DVLD) begin
                        src_s = SRC_DATA;
                    end else if (prbs_sel_s) begin
                        src_s = SRC_PRBS;
                    end else begin
                        src_s = SRC_IDLE;
                    end
                end
                default: src_s = SRC_ZERO;
            endcase
        end
    end

    for (genvar gi = 0; gi < DB_W; gi++) begin : g_lane
        logic [SER_W-1:0] word_s;
        logic [SER_W-1:0] prbs_word_s;

`ifdef LVDS_TX_PRBS_EN
        lvds_tx_prbs #(
            .SER_W (SER_W),
            .SEED  (7'(gi + 1))
        ) u_prbs (
            .clk   (CLK),
            .rst   (RST),
            .load  (state_r != S_DATA),
            .adv   (src_s == SRC_PRBS),
            .word  (prbs_word_s)
        );
`else
        assign prbs_word_s = '0;
`endif

        // Per-lane word mux
        always_comb begin
            case (src_s)
                SRC_TRAIN: word_s = TRAIN_PAT;
                SRC_SYNC:  word_s = SYNC_PAT;
                SRC_IDLE:  word_s = IDLE_PAT;
                SRC_DATA:  word_s = TX_DATA[gi*SER_W +: SER_W];
                SRC_PRBS:  word_s = prbs_word_s;
                default:   word_s = '0;
            endcase
        end

        // OSERDES shifts out bit 0 first, so the word MSB goes to bit 0
        assign oser_nxt_s[gi*SER_W +: SER_W] = SER_W'(bit_rev(10'(word_s), SER_W));
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= S_IDLE;
            train_cnt_r <= TC_W'(0);
            slot_cnt_r  <= SC_W'(0);
            frame_cnt_r <= 16'd0;
            oser_data_r <= '0;
            clk_pat_r   <= '0;
            link_up_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            train_cnt_r <= train_cnt_nxt_s;
            slot_cnt_r  <= slot_cnt_nxt_s;
            if (frame_inc_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            oser_data_r <= oser_nxt_s;
            clk_pat_r   <= (src_s == SRC_ZERO) ? '0 : CLK_PAT_ALT[SER_W-1:0];
            link_up_r   <= EN && (state_r == S_DATA);
        end
    end

    assign TX_RDY       = tx_rdy_s;
    assign OSER_DATA    = oser_data_r;
    assign OSER_CLK_PAT = clk_pat_r;
    assign LINK_UP      = link_up_r;
    assign FRAME_CNT    = frame_cnt_r;

endmodule
